// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : control_fsm
// Description : Multi-cycle control unit for a small 8-bit processor.
//               Fetches one-byte instructions (plus an optional immediate
//               byte), decodes them and sequences the ALU and register file
//               through FETCH / DECODE / EXEC / IMM / WB / HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr_data,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       zero_in,
  output logic [7:0] pc,
  output logic [2:0] alu_ctrl,
  output logic       alu_flag,
  output logic [1:0] rf_raddr1,
  output logic [1:0] rf_raddr2,
  output logic [1:0] rf_waddr,
  output logic       rf_we,
  output logic       wb_sel,
  output logic [7:0] imm,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_IMM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] c_OP_NAND = 3'b000;
  localparam logic [2:0] c_OP_ADD  = 3'b011;
  localparam logic [2:0] c_OP_SHF  = 3'b100;
  localparam logic [2:0] c_OP_LI   = 3'b010;
  localparam logic [2:0] c_OP_JZ   = 3'b101;
  localparam logic [2:0] c_OP_HALT = 3'b111;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pc;
  logic [7:0] w_pc_nxt;
  logic [7:0] r_ir;
  logic [7:0] w_ir_nxt;
  logic [7:0] r_imm;
  logic [7:0] w_imm_nxt;

  // Instruction field decode from the latched instruction register
  logic [2:0] w_op;
  logic       w_fl;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic [7:0] w_off_sx;
  logic       w_is_alu;
  logic       w_xfer;

  assign w_op     = r_ir[7:5];
  assign w_fl     = r_ir[4];
  assign w_rd     = r_ir[3:2];
  assign w_rs     = r_ir[1:0];
  assign w_off_sx = {{3{r_ir[4]}}, r_ir[4:0]};
  assign w_is_alu = (w_op == c_OP_NAND) || (w_op == c_OP_ADD) || (w_op == c_OP_SHF);

  // A byte is accepted only when the FSM is ready (state-decoded) and the source is valid
  assign w_xfer = instr_valid && instr_ready;

  // State, program counter, instruction and immediate registers with async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= 8'h00;
      r_ir    <= 8'h00;
      r_imm   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_imm   <= w_imm_nxt;
    end
  end

  // Next-state and datapath-register update logic
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_imm_nxt   = r_imm;
    case (r_state)
      S_FETCH: begin
        if (w_xfer) begin
          w_ir_nxt    = instr_data;
          w_pc_nxt    = r_pc + 8'd1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_is_alu) begin
          w_state_nxt = S_EXEC;
        end else if (w_op == c_OP_LI) begin
          w_state_nxt = S_IMM;
        end else if (w_op == c_OP_HALT) begin
          w_state_nxt = S_HALT;
        end else begin
          // JZ offset is relative to the already-incremented pc
          if ((w_op == c_OP_JZ) && zero_in) begin
            w_pc_nxt = r_pc + w_off_sx;
          end
          w_state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_WB;
      end
      S_IMM: begin
        if (w_xfer) begin
          w_imm_nxt   = instr_data;
          w_pc_nxt    = r_pc + 8'd1;
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // Moore outputs decoded purely from registered state and latched fields
  always_comb begin
    instr_ready = 1'b0;
    alu_ctrl    = 3'b000;
    alu_flag    = 1'b0;
    rf_raddr1   = 2'b00;
    rf_raddr2   = 2'b00;
    rf_waddr    = 2'b00;
    rf_we       = 1'b0;
    wb_sel      = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        instr_ready = 1'b1;
      end
      S_DECODE: begin
        rf_raddr1 = w_rd;
        rf_raddr2 = w_rs;
      end
      S_EXEC: begin
        rf_raddr1 = w_rd;
        rf_raddr2 = w_rs;
        alu_ctrl  = w_op;
        alu_flag  = w_fl;
      end
      S_IMM: begin
        instr_ready = 1'b1;
      end
      S_WB: begin
        rf_raddr1 = w_rd;
        rf_raddr2 = w_rs;
        rf_waddr  = w_rd;
        rf_we     = 1'b1;
        wb_sel    = (w_op == c_OP_LI);
        if (w_is_alu) begin
          alu_ctrl = w_op;
          alu_flag = w_fl;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        instr_ready = 1'b0;
      end
    endcase
  end

  assign pc  = r_pc;
  assign imm = r_imm;

endmodule
`default_nettype wire

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port instr_data, input, 8 bits: instruction or immediate byte from instruction memory.
REQ-004 SHALL have port instr_valid, input, 1 bit: instr_data is valid this cycle.
REQ-005 SHALL have port instr_ready, output, 1 bit: FSM accepts a byte this cycle.
REQ-006 SHALL have port zero_in, input, 1 bit: register-file zero status, sampled for JZ.
REQ-007 SHALL have port pc, output, 8 bits: address of the next byte to fetch.
REQ-008 SHALL have port alu_ctrl, output, 3 bits: drives ALU CtrlSig.
REQ-009 SHALL have port alu_flag, output, 1 bit: drives ALU Flag.
REQ-010 SHALL have ports rf_raddr1 and rf_raddr2, output, 2 bits each: register read addresses (ALU InReg1, InReg2).
REQ-011 SHALL have ports rf_waddr (output, 2 bits), rf_we (output, 1 bit) and wb_sel (output, 1 bit; 0 = ALU result, 1 = imm).
REQ-012 SHALL have port imm, output, 8 bits: latched immediate byte.
REQ-013 SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-014 SHALL decode IR as op = IR[7:5], fl = IR[4], rd = IR[3:2], rs = IR[1:0], off = IR[4:0] (signed).
REQ-015 SHALL treat opcodes as: 000 NAND/NOR, 011 ADD/SUB, 100 SRL/SLL (ALU ops); 010 LI (two-byte); 101 JZ; 111 HALT; 001, 110 NOP.
REQ-016 SHALL implement states FETCH, DECODE, EXEC, IMM, WB, HALT.
REQ-017 SHALL assert instr_ready only in FETCH and IMM; a transfer occurs only when instr_valid and instr_ready are both high on a rising clk edge.
REQ-018 In FETCH, a transfer SHALL load IR, set pc = pc+1 (mod 256) and go to DECODE; with no transfer it SHALL stay in FETCH with pc unchanged.
REQ-019 DECODE SHALL transition as follows: ALU op -> EXEC; LI -> IMM; HALT -> HALT; NOP -> FETCH; JZ -> FETCH.
REQ-020 For JZ in DECODE, if zero_in = 1 then pc SHALL become pc + sign_extend(off) (mod 256); otherwise pc SHALL be unchanged.
REQ-021 EXEC SHALL last exactly one cycle, then go to WB.
REQ-022 In IMM, a transfer SHALL latch instr_data into imm, set pc = pc+1 and go to WB; with no transfer it SHALL wait in IMM.
REQ-023 In WB, rf_we SHALL be 1 for exactly one cycle with rf_waddr = rd; wb_sel SHALL be 1 for LI and 0 otherwise; the next state SHALL be FETCH.
REQ-024 In EXEC and in WB of an ALU op, alu_ctrl SHALL equal op and alu_flag SHALL equal fl; in all other cycles alu_ctrl = 000 and alu_flag = 0.
REQ-025 rf_raddr1 SHALL equal rd and rf_raddr2 SHALL equal rs in DECODE, EXEC and WB; otherwise both SHALL be 0.
REQ-026 rf_we SHALL be 0 in every state other than WB.
REQ-027 HALT SHALL be absorbing: instr_ready = 0, pc frozen, halted = 1; only reset exits HALT.
REQ-028 All outputs SHALL be decoded from registered state; there SHALL be no combinational path from instr_valid to instr_ready.
REQ-029 An ALU instruction SHALL take 4 cycles from the fetch transfer to the WB cycle inclusive, given instr_valid held high.

Reset
REQ-030 When rst_n = 0, state SHALL become FETCH and pc, IR, imm SHALL be 0x00 immediately, without waiting for clk.
REQ-031 During reset, rf_we = 0, alu_ctrl = 000, alu_flag = 0, wb_sel = 0, halted = 0 and raddr/waddr = 0; instr_ready SHALL be 1 once in FETCH.
REQ-032 Reset asserted during any state, including WB, SHALL abort the instruction with no write pulse after the reset edge.
REQ-033 The first fetch after rst_n rises SHALL read address 0x00.

Verification
REQ-034 Reset, then 0x76 (ADD r1,r2) fetched at pc 0x00 -> DECODE, then EXEC and WB with alu_ctrl = 011, alu_flag = 1, raddr1 = 1, raddr2 = 2; WB: rf_we = 1, waddr = 1, wb_sel = 0; pc = 0x01.
REQ-035 0x4C then 0xA5 with instr_valid low for 3 cycles between the bytes -> FSM waits in IMM; then imm = 0xA5, WB with waddr = 3, wb_sel = 1; pc advanced by 2.
REQ-036 JZ 0xBE fetched at pc 0x10 with zero_in = 1 -> pc = 0x0F; the same case with zero_in = 0 -> pc = 0x11.
REQ-037 pc = 0xFF, fetch NOP 0x20 -> pc = 0x00 and state returns to FETCH without an rf_we pulse.
REQ-038 HALT 0xE0 -> halted = 1 and instr_ready = 0 held for 20 cycles despite instr_valid = 1; rst_n low -> halted = 0 and pc = 0x00 asynchronously.
REQ-039 rst_n pulsed low mid-EXEC of 0x06 (NOR r1,r2) -> no rf_we pulse; alu_ctrl = 000 immediately.
